// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encodings, bus address and codec register constants for the I2C target
package i2c_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
    } state_t;
    localparam logic [6:0] I2C_ADDR = 7'b0011010;
    localparam logic [7:0] REG_RESET = 8'h0F;
    localparam logic [7:0] REG_AIF = 8'h07;
    localparam logic [7:0] REG_SAMPLE = 8'h08;
    localparam logic [7:0] REG_ACTIVE = 8'h09;
    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ = 1'b1;
endpackage

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: synchronizes SCL/SDA and emits one-clk edge and START/STOP pulses
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [SYNC_STAGES-1:0] scl_q, sda_q;
    logic scl_s, scl_d, sda_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_q <= '1;
            sda_q <= '1;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
            sda_q <= {sda_q[SYNC_STAGES-2:0], sda};
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end
    assign scl_s = scl_q[SYNC_STAGES-1];
    assign sda_s = sda_q[SYNC_STAGES-1];
    assign scl_rise = scl_s && !scl_d;
    assign scl_fall = !scl_s && scl_d;
    assign start = scl_s && scl_d && sda_d && !sda_s;
    assign stop = scl_s && scl_d && !sda_d && sda_s;
endmodule

// File: rtl/i2c_periph.sv
// i2c_periph: I2C target that ACKs its address and bridges bytes to a register write/read port
module i2c_periph
    import i2c_pkg::*;
#(
    parameter logic [6:0] PERIPH_ADDR = I2C_ADDR,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic [3:0] state_info,
    output logic       sda_oe
);
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] shift, shift_n, ptr, ptr_n, wr_addr_n, wr_data_n, byte_in;
    logic rw, rw_n, oe_n, busy_n, wr_en_n, ack_state;
    logic sda_s, scl_rise, scl_fall, start, stop;
    i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda), .sda_s(sda_s),
        .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
    );
    assign sda = sda_oe ? 1'b0 : 1'bz;
    assign rd_addr = ptr;
    assign state_info = state;
    assign byte_in = {shift[6:0], sda_s};
    assign ack_state = state inside {S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK};
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        shift_n = shift;
        ptr_n = ptr;
        rw_n = rw;
        oe_n = sda_oe;
        busy_n = busy;
        wr_en_n = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        if (stop) begin
            state_n = S_IDLE;
            oe_n = 1'b0;
            busy_n = 1'b0;
            cnt_n = '0;
        end else if (start) begin
            state_n = S_ADDR;
            oe_n = 1'b0;
            cnt_n = '0;
        end else if (ack_state && scl_fall) begin
            // first fall pulls SDA low for the ACK, second fall ends the 9th clock
            oe_n = !sda_oe;
            busy_n = 1'b1;
            cnt_n = '0;
            if (sda_oe) begin
                state_n = state == S_ADDR_ACK ? (rw == MODE_READ ? S_RDATA : S_REG) : S_WDATA;
                if (state == S_ADDR_ACK && rw == MODE_READ) begin
                    shift_n = rd_data;
                    oe_n = !rd_data[7];
                end
            end
        end else if (scl_rise && state inside {S_ADDR, S_REG, S_WDATA}) begin
            shift_n = byte_in;
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
                cnt_n = '0;
                if (state == S_ADDR) begin
                    state_n = shift[6:0] == PERIPH_ADDR ? S_ADDR_ACK : S_WAIT_STOP;
                    busy_n = busy && shift[6:0] == PERIPH_ADDR;
                    rw_n = sda_s;
                end else if (state == S_REG) begin
                    state_n = S_REG_ACK;
                    ptr_n = byte_in;
                end else begin
                    state_n = S_WDATA_ACK;
                    wr_en_n = 1'b1;
                    wr_addr_n = ptr;
                    wr_data_n = byte_in;
                    ptr_n = ptr + 8'd1;
                end
            end
        end else if (state == S_RDATA && scl_fall) begin
            shift_n = {shift[6:0], 1'b0};
            cnt_n = cnt == 4'd7 ? 4'd0 : cnt + 4'd1;
            oe_n = cnt == 4'd7 ? 1'b0 : !shift[6];
            state_n = cnt == 4'd7 ? S_RDATA_ACK : S_RDATA;
        end else if (state == S_RDATA_ACK && scl_rise && cnt == 4'd0) begin
            // cnt marks that the master ACKed and the next fall reloads the shifter
            state_n = sda_s ? S_WAIT_STOP : S_RDATA_ACK;
            ptr_n = sda_s ? ptr : ptr + 8'd1;
            cnt_n = sda_s ? 4'd0 : 4'd1;
        end else if (state == S_RDATA_ACK && scl_fall && cnt == 4'd1) begin
            state_n = S_RDATA;
            cnt_n = '0;
            shift_n = rd_data;
            oe_n = !rd_data[7];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt <= '0;
            shift <= '0;
            ptr <= '0;
            rw <= MODE_WRITE;
            sda_oe <= 1'b0;
            busy <= 1'b0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            shift <= shift_n;
            ptr <= ptr_n;
            rw <= rw_n;
            sda_oe <= oe_n;
            busy <= busy_n;
            wr_en <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
        end
    end
endmodule

// File: tb/tb_i2c_periph.sv
// tb_i2c_periph: bit-banged I2C master with random transactions checked against a register-file model
module tb_i2c_periph;
    import i2c_pkg::*;
    localparam int Q = 50;
    localparam logic [6:0] DEV = 7'h1A;
    logic clk = 1'b0, reset = 1'b1, scl = 1'b1, m_sda = 1'b1;
    wire sda;
    logic wr_en, busy, sda_oe;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data, exp_ptr;
    logic [3:0] state_info;
    logic [7:0] regs [256];
    logic [7:0] ref_regs [256];
    logic [15:0] got [$];
    logic [7:0] wq [$];
    int checks = 0, errors = 0;
    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);
    assign rd_data = regs[rd_addr];
    always #5 clk = ~clk;
    i2c_periph dut (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .state_info(state_info), .sda_oe(sda_oe)
    );
    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 37 + 5) ^ 8'h5A;
    endfunction
    always @(posedge clk) begin
        if (reset) for (int i = 0; i < 256; i++) regs[i] <= init_val(i);
        else if (wr_en) regs[wr_addr] <= wr_data;
    end
    always @(negedge clk) if (wr_en) got.push_back({wr_addr, wr_data});
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
        end
    endtask
    task automatic bit_out(input logic b);
        m_sda = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask
    task automatic bit_in(output logic b);
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
    endtask
    task automatic start_c;
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
    endtask
    task automatic stop_c;
        m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #(4*Q);
    endtask
    task automatic send(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(v[i]);
        bit_in(ack);
    endtask
    task automatic recv(input logic ack, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            v[i] = b;
        end
        bit_out(!ack);
    endtask
    task automatic check_idle(input string tag);
        check(tag, {busy, sda_oe, state_info}, {2'b00, 4'(S_IDLE)});
    endtask
    task automatic do_write(input logic [6:0] a, input logic [7:0] r);
        logic ack, m;
        int base;
        logic [15:0] ex [$];
        m = a == DEV;
        base = got.size();
        start_c;
        send({a, 1'b0}, ack);
        check("addr_ack", ack, !m);
        check("busy", busy, m);
        send(r, ack);
        check("reg_ack", ack, !m);
        if (m) exp_ptr = r;
        foreach (wq[i]) begin
            send(wq[i], ack);
            check("data_ack", ack, !m);
            if (m) begin
                ex.push_back({exp_ptr, wq[i]});
                ref_regs[exp_ptr] = wq[i];
                exp_ptr++;
            end
        end
        if (!m) check("wait_stop", state_info, S_WAIT_STOP);
        stop_c;
        check_idle("wr_idle");
        check("wr_ptr", rd_addr, exp_ptr);
        check("wr_count", got.size() - base, ex.size());
        foreach (ex[i]) if (base + i < got.size()) check("wr_beat", got[base + i], ex[i]);
    endtask
    task automatic do_read(input logic [7:0] r, input int n);
        logic ack;
        logic [7:0] v;
        start_c;
        send({DEV, 1'b0}, ack);
        check("rd_waddr_ack", ack, 0);
        send(r, ack);
        check("rd_reg_ack", ack, 0);
        exp_ptr = r;
        start_c;
        send({DEV, 1'b1}, ack);
        check("rd_addr_ack", ack, 0);
        for (int i = 0; i < n; i++) begin
            recv(i < n - 1, v);
            check("rd_byte", v, ref_regs[exp_ptr]);
            if (i < n - 1) exp_ptr++;
        end
        check("rd_nack", {sda_oe, state_info}, {1'b0, 4'(S_WAIT_STOP)});
        check("rd_ptr", rd_addr, exp_ptr);
        stop_c;
        check_idle("rd_idle");
    endtask
    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        logic ack;
        int base, n;
        for (int i = 0; i < 256; i++) ref_regs[i] = init_val(i);
        exp_ptr = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        check_idle("rst_idle");
        check("rst_regs", {wr_en, wr_addr, wr_data, rd_addr}, 25'h0);
        reset = 1'b0;
        #(4*Q);
        wq = '{8'h80};
        do_write(DEV, REG_AIF);
        wq.delete();
        do_write(7'h1B, 8'h07);
        wq = '{8'h11, 8'h22, 8'h33};
        do_write(DEV, 8'hFE);
        check("wrap_ptr", rd_addr, 8'h01);
        wq = '{8'h01, 8'hA5};
        do_write(DEV, REG_ACTIVE);
        do_read(REG_ACTIVE, 2);
        base = got.size();
        start_c;
        send({DEV, 1'b0}, ack);
        send(8'h20, ack);
        for (int i = 0; i < 5; i++) bit_out(1'($urandom));
        stop_c;
        check_idle("abort_idle");
        check("abort_ptr", rd_addr, 8'h20);
        check("abort_count", got.size() - base, 0);
        exp_ptr = 8'h20;
        start_c;
        for (int i = 7; i >= 0; i--) bit_out(i == 0 ? 1'b0 : DEV[i-1]);
        m_sda = 1'b1;
        for (int i = 0; i < 40 && !sda_oe; i++) @(posedge clk);
        check("ack_drive", sda_oe, 1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid", {sda_oe, state_info}, {1'b0, 4'(S_IDLE)});
        reset = 1'b0;
        exp_ptr = 8'h00;
        for (int i = 0; i < 256; i++) ref_regs[i] = init_val(i);
        stop_c;
        wq = '{8'h9C};
        do_write(DEV, REG_SAMPLE);
        for (int t = 0; t < 14; t++) begin
            n = $urandom_range(1, 3);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
            case ($urandom_range(0, 2))
                0: do_write(DEV, 8'($urandom));
                1: do_write(7'($urandom), 8'($urandom));
                default: do_read(8'($urandom), n);
            endcase
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
